// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Non-memory instructions pass through combinationally. Loads and stores run a
// registered req/ack transaction with a word-addressed data memory and stall
// the pipeline until the single DONE cycle in which MEM/WB samples the result.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses in IDLE (no memory request, 2-cycle op, err_o pulse).
module mem_stage_lsu #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_rf_we,
    input  logic [4:0]  in_wR,
    input  logic [31:0] in_alu_res,
    output logic        stall_o,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        rf_we_o,
    output logic [4:0]  wR_o,
    output logic [31:0] wD_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(ACK_TIMEOUT);

    state_t          r_state;
    logic            r_dm_req;
    logic            r_dm_we;
    logic [31:0]     r_dm_addr;
    logic [3:0]      r_dm_wstrb;
    logic [31:0]     r_dm_wdata;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_off;
    logic            r_is_load;
    logic [TO_W-1:0] r_cnt;
    logic            r_err;
    logic [31:0]     r_ld_data;

    logic            w_mop;
    logic            w_sz_b;
    logic            w_sz_h;
    logic            w_misal;
    logic [3:0]      w_wstrb;
    logic [31:0]     w_wdata;
    logic [7:0]      w_bsel;
    logic [15:0]     w_hsel;
    logic [31:0]     w_ld_ext;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_to;

    assign w_mop     = in_valid & (in_is_load | in_is_store);
    assign w_cnt_nxt = r_cnt + TO_W'(1);
    // The abort fires on the ACK_TIMEOUT-th REQ cycle; zero disables it.
    assign w_to      = (ACK_TIMEOUT != 0) && (w_cnt_nxt == TO_VAL);

    assign dm_req   = r_dm_req;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_wstrb = r_dm_wstrb;
    assign dm_wdata = r_dm_wdata;

    // Access size decode; undefined encodings fall back to a full word.
    // A load flag wins if both load and store are raised.
    always_comb begin
        w_sz_b = 1'b0;
        w_sz_h = 1'b0;
        if (in_is_load) begin
            w_sz_b = (in_funct3 == 3'b000) | (in_funct3 == 3'b100);
            w_sz_h = (in_funct3 == 3'b001) | (in_funct3 == 3'b101);
        end else begin
            w_sz_b = (in_funct3 == 3'b000);
            w_sz_h = (in_funct3 == 3'b001);
        end
    end

    // Store lane enables and lane-replicated data; loads never write lanes.
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = in_wdata;
        if (w_sz_b) begin
            w_wdata = {4{in_wdata[7:0]}};
        end else if (w_sz_h) begin
            w_wdata = {2{in_wdata[15:0]}};
        end
        if (!in_is_load) begin
            if (w_sz_b)      w_wstrb = 4'b0001 << in_addr[1:0];
            else if (w_sz_h) w_wstrb = 4'b0011 << {in_addr[1], 1'b0};
            else             w_wstrb = 4'b1111;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Half with odd address, or word not on a 4-byte boundary.
    assign w_misal = (w_sz_h & in_addr[0]) | (~w_sz_b & ~w_sz_h & (|in_addr[1:0]));
`else
    // Misaligned low bits are simply ignored by the lane logic.
    assign w_misal = 1'b0;
`endif

    // Load extraction from the returned word using the latched size/offset.
    always_comb begin
        w_bsel = dm_rdata[{r_ld_off, 3'b000} +: 8];
        w_hsel = r_ld_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_ld_f3)
            3'b000:  w_ld_ext = {{24{w_bsel[7]}}, w_bsel};
            3'b100:  w_ld_ext = {24'b0, w_bsel};
            3'b001:  w_ld_ext = {{16{w_hsel[15]}}, w_hsel};
            3'b101:  w_ld_ext = {16'b0, w_hsel};
            default: w_ld_ext = dm_rdata;
        endcase
    end

    // Control FSM: latch the request in IDLE, wait for ack or timeout, retire in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wstrb <= '0;
            r_dm_wdata <= '0;
            r_ld_f3    <= '0;
            r_ld_off   <= '0;
            r_is_load  <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_ld_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mop) begin
                        r_dm_we    <= ~in_is_load;
                        r_dm_addr  <= {in_addr[31:2], 2'b00};
                        r_dm_wstrb <= w_wstrb;
                        r_dm_wdata <= w_wdata;
                        r_ld_f3    <= in_funct3;
                        r_ld_off   <= in_addr[1:0];
                        r_is_load  <= in_is_load;
                        if (w_misal) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dm_req <= 1'b1;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_nxt;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dm_ack) begin
                        r_ld_data <= w_ld_ext;
                        r_dm_req  <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (w_to) begin
                        r_dm_req <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Writeback/stall outputs. The IDLE stall is masked while reset is held so
    // an abandoned op does not keep the pipeline frozen during reset.
    always_comb begin
        stall_o = 1'b0;
        rf_we_o = 1'b0;
        wR_o    = in_wR;
        wD_o    = 32'b0;
        err_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mop) begin
                    stall_o = rst_n;
                end else begin
                    rf_we_o = in_valid & in_rf_we;
                    wD_o    = in_alu_res;
                end
            end
            S_REQ: stall_o = 1'b1;
            S_DONE: begin
                err_o = r_err;
                if (r_is_load) begin
                    rf_we_o = in_rf_we & ~r_err;
                    wD_o    = r_err ? 32'b0 : r_ld_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the driver pushes the expected MEM/WB
// result of each instruction; a monitor pops and compares whenever the unit
// presents an unstalled valid instruction. A memory model acks after a
// programmable number of REQ cycles (or never).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_is_load, in_is_store, in_rf_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, in_alu_res;
    logic [4:0]  in_wR;
    logic        stall_o, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        rf_we_o, err_o;
    logic [4:0]  wR_o;
    logic [31:0] wD_o;

    typedef struct {
        logic        rf_we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ack_dly = -1;
    int   req_cnt = 0;
    int   sc = 0;

    mem_stage_lsu #(.ACK_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rf_we(in_rf_we), .in_wR(in_wR), .in_alu_res(in_alu_res),
        .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .rf_we_o(rf_we_o), .wR_o(wR_o), .wD_o(wD_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic er, input int st);
        exp_t e;
        e.rf_we = we; e.wr = wr; e.wd = wd; e.err = er; e.stalls = st;
        return e;
    endfunction

    task automatic set_in(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] alu, input logic rfwe, input logic [4:0] wr);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_alu_res = alu; in_rf_we = rfwe; in_wR = wr;
    endtask

    // Runs one instruction to retirement; optionally checks the issued request
    // on the first REQ cycle, or that no request appears at all.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] alu, input logic rfwe, input logic [4:0] wr,
                          input logic [31:0] rdata, input int ackd, input exp_t e,
                          input logic chk_dm, input logic no_req,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata);
        logic done;
        logic [31:0] e_addr;
        done = 1'b0;
        e_addr = {addr[31:2], 2'b00};
        set_in(ld, st, f3, addr, wdata, alu, rfwe, wr);
        dm_rdata = rdata;
        ack_dly = ackd;
        sb.push_back(e);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (no_req) chk("no_req", {31'b0, dm_req}, 32'd0);
            if (n == 2 && chk_dm) begin
                chk("dm_req", {31'b0, dm_req}, 32'd1);
                chk("dm_addr", dm_addr, e_addr);
                chk("dm_we", {31'b0, dm_we}, {31'b0, st});
                chk("dm_wstrb", {28'b0, dm_wstrb}, {28'b0, e_strb});
                if (st) chk("dm_wdata", dm_wdata, e_wdata);
            end
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("op_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Memory model: ack on the ack_dly-th REQ cycle (0 = first), never if negative.
    initial begin
        dm_ack = 1'b0;
        dm_rdata = '0;
        forever begin
            @(negedge clk);
            if (dm_req) begin
                dm_ack = (req_cnt == ack_dly);
                req_cnt++;
            end else begin
                dm_ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Monitor: counts stall cycles and checks every retired instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sc = 0;
            end else if (stall_o) begin
                sc++;
            end else if (in_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rf_we_o", {31'b0, rf_we_o}, {31'b0, e.rf_we});
                    chk("wR_o", {27'b0, wR_o}, {27'b0, e.wr});
                    chk("wD_o", wD_o, e.wd);
                    chk("err_o", {31'b0, err_o}, {31'b0, e.err});
                    chk("stall_cycles", 32'(sc), 32'(e.stalls));
                    chk("dm_req_retire", {31'b0, dm_req}, 32'd0);
                end
                sc = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_rf_we = 1'b0;
        in_funct3 = '0; in_addr = '0; in_wdata = '0; in_alu_res = '0; in_wR = '0;
        #2;
        chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_wstrb", {28'b0, dm_wstrb}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU pass-through, zero latency
        run_op(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 1, 5'd5, 32'h0, -1,
               mk(1, 5'd5, 32'h1234, 0, 0), 0, 1, 4'h0, 32'h0);
        // LB sign-extended, ack 2 cycles after req
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 1, 5'd7, 32'h80FF_0000, 2,
               mk(1, 5'd7, 32'hFFFF_FF80, 0, 4), 1, 0, 4'h0, 32'h0);
        // LHU upper half, same-cycle ack
        run_op(1, 0, 3'b101, 32'h202, 32'h0, 32'h0, 1, 5'd8, 32'hBEEF_1234, 0,
               mk(1, 5'd8, 32'h0000_BEEF, 0, 2), 1, 0, 4'h0, 32'h0);
        // SB lane 1, store never writes back even with in_rf_we=1
        run_op(0, 1, 3'b000, 32'h11, 32'h1234_56AB, 32'h55, 1, 5'd3, 32'h0, 0,
               mk(0, 5'd3, 32'h0, 0, 2), 1, 0, 4'b0010, 32'hABAB_ABAB);
        // SH upper half
        run_op(0, 1, 3'b001, 32'h12, 32'h0000_CAFE, 32'h0, 0, 5'd4, 32'h0, 1,
               mk(0, 5'd4, 32'h0, 0, 3), 1, 0, 4'b1100, 32'hCAFE_CAFE);
        // SW
        run_op(0, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 5'd4, 32'h0, 0,
               mk(0, 5'd4, 32'h0, 0, 2), 1, 0, 4'b1111, 32'hDEAD_BEEF);
        // LH sign-extended lower half
        run_op(1, 0, 3'b001, 32'h40, 32'h0, 32'h0, 1, 5'd10, 32'h1234_8001, 0,
               mk(1, 5'd10, 32'hFFFF_8001, 0, 2), 1, 0, 4'h0, 32'h0);
        // LBU byte 1 zero-extended
        run_op(1, 0, 3'b100, 32'h41, 32'h0, 32'h0, 1, 5'd11, 32'h0000_F500, 0,
               mk(1, 5'd11, 32'h0000_00F5, 0, 2), 1, 0, 4'h0, 32'h0);
        // LW with in_rf_we=0: data still presented, no write
        run_op(1, 0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 5'd12, 32'hCAFE_F00D, 1,
               mk(0, 5'd12, 32'hCAFE_F00D, 0, 3), 1, 0, 4'h0, 32'h0);
        // Timeout: no ack, 4 REQ cycles then error
        run_op(1, 0, 3'b010, 32'h50, 32'h0, 32'h0, 1, 5'd9, 32'hFFFF_FFFF, -1,
               mk(0, 5'd9, 32'h0, 1, 5), 1, 0, 4'h0, 32'h0);
        // Ack on the same cycle the timeout would fire: counts as ack
        run_op(1, 0, 3'b010, 32'h54, 32'h0, 32'h0, 1, 5'd9, 32'h1111_2222, 3,
               mk(1, 5'd9, 32'h1111_2222, 0, 5), 1, 0, 4'h0, 32'h0);
        // Undefined load funct3 behaves as LW
        run_op(1, 0, 3'b011, 32'h70, 32'h0, 32'h0, 1, 5'd13, 32'h89AB_CDEF, 0,
               mk(1, 5'd13, 32'h89AB_CDEF, 0, 2), 1, 0, 4'h0, 32'h0);
        // ALU op with in_rf_we=0
        run_op(0, 0, 3'b000, 32'h0, 32'h0, 32'hABCD_EF01, 0, 5'd12, 32'h0, -1,
               mk(0, 5'd12, 32'hABCD_EF01, 0, 0), 0, 1, 4'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        // Misaligned LW traps without a memory request
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 5'd14, 32'h0, 0,
               mk(0, 5'd14, 32'h0, 1, 1), 0, 1, 4'h0, 32'h0);
`endif

        // Reset in the middle of a load, then the held load reissues
        set_in(1, 0, 3'b010, 32'h60, 32'h0, 32'h0, 1, 5'd10);
        dm_rdata = 32'h0BAD_F00D;
        ack_dly = -1;
        sb.push_back(mk(1, 5'd10, 32'h0BAD_F00D, 0, 2));
        @(negedge clk);
        @(negedge clk);
        chk("mid_dm_req", {31'b0, dm_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dm_req", {31'b0, dm_req}, 32'd0);
        chk("async_stall", {31'b0, stall_o}, 32'd0);
        ack_dly = 0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            logic done;
            done = 1'b0;
            for (int n = 1; n <= 20; n++) begin
                @(negedge clk);
                if (!stall_o) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) chk("reissue_bound", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
